// File: rtl/u409_flash_cycle.sv
// u409_flash_cycle: NOR flash bus-cycle sequencer for U409; define FLASH_WP_EN to hardware-lock the boot sector
module u409_flash_cycle #(
    parameter int SETUP_CLK   = 1,
    parameter int READ_CLK    = 4,
    parameter int WRITE_CLK   = 2,
    parameter int HOLD_CLK    = 1,
    parameter int RST_LOW_CLK = 20,
    parameter int RST_REC_CLK = 8
) (
    input  logic        CLK40,
    input  logic        RESET,
    input  logic        TSn,
    input  logic        RnW,
    input  logic        FLASH_SPACE,
    input  logic [23:1] A,
    input  logic        F_RDY,
    output logic        F_ENn,
    output logic        F_READn,
    output logic        F_WRITEn,
    output logic        F_RSTn,
    output logic        F_WPn,
    output logic        F_ACK
);
    function automatic int mx(input int a, input int b);
        return a > b ? a : b;
    endfunction

    localparam int MAXP = mx(mx(mx(SETUP_CLK, READ_CLK), mx(WRITE_CLK, HOLD_CLK)), mx(RST_LOW_CLK, RST_REC_CLK));
    localparam int CW = $clog2(MAXP + 1);

    if (SETUP_CLK < 1 || READ_CLK < 1 || WRITE_CLK < 1 || HOLD_CLK < 1 || RST_LOW_CLK < 1 || RST_REC_CLK < 1) begin : g_bad_param
        $error("u409_flash_cycle: every timing parameter must be at least 1");
    end

    typedef enum logic [2:0] {INIT, RECOV, IDLE, BUSY, SETUP, RD, WR, HOLD} state_t;
    typedef logic [CW-1:0] cnt_t;

    state_t st, nxt;
    cnt_t cnt, cnt_n;
    logic rdy_m, rdy_s, pend, rnw_q, wp_blk;
    logic [23:1] a_q;

    function automatic cnt_t ld(input state_t s);
        return cnt_t'(s == INIT  ? RST_LOW_CLK - 1 :
                      s == RECOV ? RST_REC_CLK - 1 :
                      s == SETUP ? SETUP_CLK - 1 :
                      s == RD    ? READ_CLK - 1 :
                      s == WR    ? WRITE_CLK - 1 :
                      s == HOLD  ? HOLD_CLK - 1 : 0);
    endfunction

    wire ts_hit = !TSn && FLASH_SPACE;
    wire done = cnt == '0;

`ifdef FLASH_WP_EN
    assign F_WPn = 1'b0;
    assign wp_blk = a_q[23:16] == 8'h00;
`else
    assign F_WPn = 1'b1;
    assign wp_blk = 1'b0;
`endif

    always_comb begin
        nxt = st;
        case (st)
            INIT:    nxt = done ? RECOV : INIT;
            RECOV:   nxt = done ? IDLE : RECOV;
            IDLE:    nxt = (ts_hit || pend) ? (rdy_s ? SETUP : BUSY) : IDLE;
            BUSY:    nxt = rdy_s ? SETUP : BUSY;
            SETUP:   nxt = done ? (rnw_q ? RD : WR) : SETUP;
            RD:      nxt = done ? HOLD : RD;
            WR:      nxt = done ? HOLD : WR;
            default: nxt = done ? IDLE : HOLD;
        endcase
        cnt_n = nxt != st ? ld(nxt) : done ? cnt : cnt - cnt_t'(1);
    end

    // outputs are registered from the next state so strobes line up with the state they belong to
    always_ff @(posedge CLK40) begin
        rdy_m <= F_RDY;
        rdy_s <= rdy_m;
        if (ts_hit && !pend && (st == INIT || st == RECOV || st == IDLE)) begin
            a_q   <= A;
            rnw_q <= RnW;
        end
        if (RESET) begin
            st       <= INIT;
            cnt      <= ld(INIT);
            pend     <= 1'b0;
            F_ENn    <= 1'b1;
            F_READn  <= 1'b1;
            F_WRITEn <= 1'b1;
            F_ACK    <= 1'b0;
            F_RSTn   <= 1'b0;
        end else begin
            st       <= nxt;
            cnt      <= cnt_n;
            pend     <= (st == INIT || st == RECOV) && (pend || ts_hit);
            F_RSTn   <= nxt != INIT;
            F_ENn    <= nxt == INIT || nxt == RECOV || nxt == IDLE || nxt == BUSY;
            F_READn  <= nxt != RD;
            F_WRITEn <= nxt != WR || wp_blk;
            F_ACK    <= cnt_n == '0 && (nxt == RD || (nxt == HOLD && !rnw_q));
        end
    end
endmodule

// File: tb/tb_u409_flash_cycle.sv
// tb_u409_flash_cycle: directed scoreboard bench for u409_flash_cycle
module tb_u409_flash_cycle;
    logic clk = 1'b0, RESET = 1'b1, TSn = 1'b1, RnW = 1'b1, FLASH_SPACE = 1'b0, F_RDY = 1'b1;
    logic [23:1] A = '0;
    logic F_ENn, F_READn, F_WRITEn, F_RSTn, F_WPn, F_ACK;
    int n_assert = 0, n_fail = 0;

    typedef struct {
        string tag;
        logic [4:0] v;
    } exp_t;
    exp_t sb[$];

`ifdef FLASH_WP_EN
    localparam logic WP = 1'b1;
`else
    localparam logic WP = 1'b0;
`endif

    always #5 clk = ~clk;

    u409_flash_cycle dut (
        .CLK40(clk), .RESET(RESET), .TSn(TSn), .RnW(RnW), .FLASH_SPACE(FLASH_SPACE), .A(A), .F_RDY(F_RDY),
        .F_ENn(F_ENn), .F_READn(F_READn), .F_WRITEn(F_WRITEn), .F_RSTn(F_RSTn), .F_WPn(F_WPn), .F_ACK(F_ACK)
    );

    // observed vector order: {F_RSTn, F_ENn, F_READn, F_WRITEn, F_ACK}
    function automatic logic [4:0] obs();
        return {F_RSTn, F_ENn, F_READn, F_WRITEn, F_ACK};
    endfunction

    task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input int n, input logic [4:0] v);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.tag = $sformatf("%s[%0d]", tag, i);
            e.v = v;
            sb.push_back(e);
        end
    endtask

    task automatic push_rd(input string t);
        push({t, " setup"}, 1, 5'b10110);
        push({t, " rd"}, 3, 5'b10010);
        push({t, " rd_ack"}, 1, 5'b10011);
        push({t, " hold"}, 1, 5'b10110);
        push({t, " idle"}, 1, 5'b11110);
    endtask

    task automatic push_wr(input string t, input logic we);
        push({t, " setup"}, 1, 5'b10110);
        push({t, " wr"}, 2, we ? 5'b10100 : 5'b10110);
        push({t, " hold_ack"}, 1, 5'b10111);
        push({t, " idle"}, 1, 5'b11110);
    endtask

    task automatic apply(input int c, input int ts_at, input logic fs, input int rdy_at, input int rst_at);
        TSn = !(c == ts_at);
        FLASH_SPACE = fs && (c == ts_at);
        F_RDY = c >= rdy_at;
        RESET = c == rst_at;
    endtask

    // c = 0 is the current cycle; every following cycle pops one expected vector
    task automatic run(input int ts_at, input logic fs, input int rdy_at, input int rst_at, input logic rnw, input logic [23:1] a);
        exp_t e;
        int c;
        c = 0;
        RnW = rnw;
        A = a;
        apply(c, ts_at, fs, rdy_at, rst_at);
        while (sb.size() > 0) begin
            @(negedge clk);
            c++;
            e = sb.pop_front();
            chk(e.tag, obs(), e.v);
            apply(c, ts_at, fs, rdy_at, rst_at);
        end
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("reset_state", obs(), 5'b01110);
        chk("wpn", {4'b0, F_WPn}, {4'b0, !WP});
        push("init", 19, 5'b01110);
        push("recov", 9, 5'b11110);
        push_rd("pend");
        run(5, 1'b1, 0, -1, 1'b1, 23'h000100);
        push_rd("rd1");
        run(0, 1'b1, 0, -1, 1'b1, 23'h012340);
        push_rd("rd_b2b");
        run(0, 1'b1, 0, -1, 1'b1, 23'h7fffff);
        push_wr("wr1", 1'b1);
        run(0, 1'b1, 0, -1, 1'b0, 23'h020000);
        push("nofs", 3, 5'b11110);
        run(0, 1'b0, 0, -1, 1'b1, 23'h012340);
        push("rdy_lo", 3, 5'b11110);
        run(-1, 1'b1, 99, -1, 1'b1, 23'h0);
        push("busy", 32, 5'b11110);
        push_rd("busy_rd");
        run(0, 1'b1, 30, -1, 1'b1, 23'h000200);
        push("abort setup", 1, 5'b10110);
        push("abort rd", 2, 5'b10010);
        push("abort init", 20, 5'b01110);
        push("abort recov", 9, 5'b11110);
        run(0, 1'b1, 0, 3, 1'b1, 23'h000300);
        push_wr("wp", !WP);
        run(0, 1'b1, 0, -1, 1'b0, 23'h001000);
        chk("wpn_end", {4'b0, F_WPn}, {4'b0, !WP});
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
